noc_system: RTL and testbench

Two-port packet distributor for the NVCIM communication fabric. It accepts a stream of flits on a single injection port (`stab`) and routes each packet, wormhole style, to one of two ejection ports (`flee0`, `flee1`). The destination comes from the head flit, and each output has its own buffer. Traffic to one port is not blocked by back-pressure on the other port, except while a packet bound for the stalled port is mid-flight.

---
 rtl/noc_system.sv | 184 ++++++++++++++++++
 tb/tb_noc_system.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_system.sv
// Two-port wormhole packet distributor: one injection port, two buffered ejection ports.
// The head flit's destination bit locks the route until the packet's tail flit passes.

module noc_system_fifo #(
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic [DW-1:0] data_o,
   output logic          valid_o,
   output logic          full_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem_q [FIFO_DEPTH];
   logic [DW-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(FIFO_DEPTH));
   assign valid_o = (count_q != '0);
   assign data_o  = mem_q[rd_ptr_q];

   // Push is gated on the pre-edge full flag, so a full buffer never accepts even with a pop pending.
   always_comb begin
      do_push  = push_i & ~full_o;
      do_pop   = pop_i & valid_o;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

module noc_system #(
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [DW-1:0] data_i_stab,
   input  logic          valid_i_stab,
   output logic          ready_o_stab,
   output logic [DW-1:0] data_o_flee0,
   output logic          valid_o_flee0,
   input  logic          ready_i_flee0,
   output logic [DW-1:0] data_o_flee1,
   output logic          valid_o_flee1,
   input  logic          ready_i_flee1
);

   localparam logic [1:0] FLIT_BODY   = 2'b00;
   localparam logic [1:0] FLIT_HEAD   = 2'b01;
   localparam logic [1:0] FLIT_TAIL   = 2'b10;
   localparam logic [1:0] FLIT_SINGLE = 2'b11;

   typedef enum logic [1:0] {
      ROUTE_IDLE  = 2'd0,
      ROUTE_LOCK0 = 2'd1,
      ROUTE_LOCK1 = 2'd2
   } route_e;

   route_e     route_q, route_d;
   logic [1:0] flit_type;
   logic       flit_dest;
   logic       target;
   logic       is_err;
   logic       target_full;
   logic       accept;
   logic       push0, push1;
   logic       full0, full1;

   always_comb begin
      flit_type   = data_i_stab[DW-1 -: 2];
      flit_dest   = data_i_stab[DW-3];
      target      = 1'b0;
      is_err      = 1'b0;
      route_d     = route_q;
      case (route_q)
         ROUTE_IDLE: begin
            if ((flit_type == FLIT_HEAD) || (flit_type == FLIT_SINGLE)) begin
               target = flit_dest;
            end else begin
               is_err = 1'b1;
            end
         end
         ROUTE_LOCK0: target = 1'b0;
         ROUTE_LOCK1: target = 1'b1;
         default:     is_err = 1'b1;
      endcase
      target_full  = target ? full1 : full0;
      ready_o_stab = is_err | ~target_full;
      accept       = valid_i_stab & ready_o_stab;
      push0        = accept & ~is_err & ~target;
      push1        = accept & ~is_err & target;
      // Orphan body/tail flits are dropped in IDLE; inside a packet only the tail releases the lock.
      if (accept) begin
         case (route_q)
            ROUTE_IDLE: begin
               if (flit_type == FLIT_HEAD) begin
                  route_d = flit_dest ? ROUTE_LOCK1 : ROUTE_LOCK0;
               end
            end
            ROUTE_LOCK0, ROUTE_LOCK1: begin
               if (flit_type == FLIT_TAIL) begin
                  route_d = ROUTE_IDLE;
               end
            end
            default: route_d = ROUTE_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         route_q <= ROUTE_IDLE;
      end else begin
         route_q <= route_d;
      end
   end

   noc_system_fifo #(
      .DW         (DW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo0 (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (push0),
      .data_i  (data_i_stab),
      .pop_i   (ready_i_flee0),
      .data_o  (data_o_flee0),
      .valid_o (valid_o_flee0),
      .full_o  (full0)
   );

   noc_system_fifo #(
      .DW         (DW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo1 (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (push1),
      .data_i  (data_i_stab),
      .pop_i   (ready_i_flee1),
      .data_o  (data_o_flee1),
      .valid_o (valid_o_flee1),
      .full_o  (full1)
   );

endmodule

// File: tb/tb_noc_system.sv
// Randomized self-checking bench for noc_system against a queue-based reference model.
// The model tracks per-port flit queues and the route lock from the flit-type rules.

module tb_noc_system;

   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic [DW-1:0] data_i_stab = '0;
   logic          valid_i_stab = 1'b0;
   logic          ready_o_stab;
   logic [DW-1:0] data_o_flee0;
   logic          valid_o_flee0;
   logic          ready_i_flee0 = 1'b0;
   logic [DW-1:0] data_o_flee1;
   logic          valid_o_flee1;
   logic          ready_i_flee1 = 1'b0;

   int            checkCount = 0;
   int            errorCount = 0;
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   int            lockPort = -1;
   int            rxCount0 = 0;
   int            rxCount1 = 0;
   int            stallSeen = 0;
   bit            lastAccept = 1'b0;

   noc_system #(
      .DW         (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .data_i_stab   (data_i_stab),
      .valid_i_stab  (valid_i_stab),
      .ready_o_stab  (ready_o_stab),
      .data_o_flee0  (data_o_flee0),
      .valid_o_flee0 (valid_o_flee0),
      .ready_i_flee0 (ready_i_flee0),
      .data_o_flee1  (data_o_flee1),
      .valid_o_flee1 (valid_o_flee1),
      .ready_i_flee1 (ready_i_flee1)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [DW-1:0] mkFlit(input logic [1:0] ftype, input int dest, input int payload);
      logic [DW-1:0] f;
      f           = DW'(payload);
      f[DW-1:DW-2] = ftype;
      f[DW-3]     = dest[0];
      return f;
   endfunction

   // An error flit is a body or tail arriving while no packet is open.
   function automatic bit modelErr(input logic [DW-1:0] d);
      return (lockPort < 0) && (d[DW-1:DW-2] == 2'b00 || d[DW-1:DW-2] == 2'b10);
   endfunction

   function automatic int modelTarget(input logic [DW-1:0] d);
      return (lockPort >= 0) ? lockPort : int'(d[DW-3]);
   endfunction

   function automatic bit modelReady(input logic [DW-1:0] d);
      if (modelErr(d)) return 1'b1;
      if (modelTarget(d) == 0) return q0.size() < DEPTH;
      return q1.size() < DEPTH;
   endfunction

   // One clock: compare outputs mid-cycle, then advance the model across the rising edge.
   task automatic tick();
      bit            expReady;
      bit            accept;
      bit            err;
      int            tgt;
      bit            pop0;
      bit            pop1;
      logic [DW-1:0] d;
      @(negedge clk);
      d        = data_i_stab;
      expReady = modelReady(d);
      err      = modelErr(d);
      tgt      = modelTarget(d);
      checkOutput("ready", DW'(ready_o_stab), DW'(expReady));
      checkOutput("valid0", DW'(valid_o_flee0), DW'(q0.size() != 0));
      checkOutput("valid1", DW'(valid_o_flee1), DW'(q1.size() != 0));
      if (q0.size() != 0) checkOutput("data0", data_o_flee0, q0[0]);
      if (q1.size() != 0) checkOutput("data1", data_o_flee1, q1[0]);
      if (valid_i_stab && !expReady) stallSeen++;
      accept = valid_i_stab && expReady;
      pop0   = (q0.size() != 0) && ready_i_flee0;
      pop1   = (q1.size() != 0) && ready_i_flee1;
      @(posedge clk);
      if (pop0) begin
         void'(q0.pop_front());
         rxCount0++;
      end
      if (pop1) begin
         void'(q1.pop_front());
         rxCount1++;
      end
      if (accept) begin
         if (!err) begin
            if (tgt == 0) q0.push_back(d);
            else q1.push_back(d);
         end
         if (lockPort < 0 && d[DW-1:DW-2] == 2'b01) lockPort = int'(d[DW-3]);
         else if (lockPort >= 0 && d[DW-1:DW-2] == 2'b10) lockPort = -1;
      end
      lastAccept = accept;
      #1;
   endtask

   task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit r0, input bit r1);
      valid_i_stab  = v;
      data_i_stab   = d;
      ready_i_flee0 = r0;
      ready_i_flee1 = r1;
      tick();
   endtask

   task automatic applyReset();
      rstn         = 1'b0;
      valid_i_stab = 1'b0;
      data_i_stab  = '0;
      q0.delete();
      q1.delete();
      lockPort = -1;
      @(negedge clk);
      checkOutput("rstValid0", DW'(valid_o_flee0), '0);
      checkOutput("rstValid1", DW'(valid_o_flee1), '0);
      checkOutput("rstData0", data_o_flee0, '0);
      checkOutput("rstData1", data_o_flee1, '0);
      checkOutput("rstReady", DW'(ready_o_stab), DW'(1));
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drainAll();
      int cnt = 0;
      while ((q0.size() != 0 || q1.size() != 0) && cnt < 200) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b1);
         cnt++;
      end
      checkOutput("drainLeft", DW'(q0.size() + q1.size()), '0);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
   endtask

   initial begin
      int sent;
      int cyc;
      int rxBase;
      int accepted;
      logic [DW-1:0] rnd;

      #2;
      applyReset();

      $display("[TB] single flits alternating destinations");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, mkFlit(2'b11, i % 2, 100 + i), 1'b1, 1'b1);
      end
      drainAll();

      $display("[TB] wormhole lock to flee1");
      rxBase = rxCount1;
      applyStimulus(1'b1, mkFlit(2'b01, 1, 1), 1'b1, 1'b1);
      applyStimulus(1'b1, mkFlit(2'b00, 1, 2), 1'b1, 1'b1);
      applyStimulus(1'b1, mkFlit(2'b00, 0, 3), 1'b1, 1'b1);
      applyStimulus(1'b1, mkFlit(2'b10, 0, 4), 1'b1, 1'b1);
      applyStimulus(1'b1, mkFlit(2'b11, 0, 5), 1'b1, 1'b1);
      drainAll();
      checkOutput("wormRx1", DW'(rxCount1 - rxBase), DW'(4));

      $display("[TB] back-pressure stream on flee0");
      sent      = 0;
      cyc       = 0;
      stallSeen = 0;
      rxBase    = rxCount0;
      while (sent < 1500 && cyc < 40000) begin
         applyStimulus(1'b1, mkFlit(2'b11, 0, sent), (cyc % 16) == 0, 1'b1);
         if (lastAccept) sent++;
         cyc++;
      end
      checkOutput("bpSent", DW'(sent), DW'(1500));
      drainAll();
      checkOutput("bpStalled", DW'(stallSeen > 0), DW'(1));
      checkOutput("bpRx0", DW'(rxCount0 - rxBase), DW'(1500));

      $display("[TB] isolation with flee0 stalled");
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, mkFlit(2'b11, 0, 200 + i), 1'b0, 1'b1);
      end
      accepted = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, mkFlit(2'b11, 1, 300 + i), 1'b0, 1'b1);
         if (lastAccept) accepted++;
      end
      checkOutput("isoAccepted", DW'(accepted), DW'(20));
      drainAll();

      $display("[TB] orphan flits in idle");
      applyStimulus(1'b1, mkFlit(2'b00, 1, 400), 1'b1, 1'b1);
      applyStimulus(1'b1, mkFlit(2'b10, 0, 401), 1'b1, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("orphanV0", DW'(valid_o_flee0), '0);
      checkOutput("orphanV1", DW'(valid_o_flee1), '0);

      $display("[TB] reset mid-packet");
      applyStimulus(1'b1, mkFlit(2'b01, 1, 500), 1'b0, 1'b0);
      applyStimulus(1'b1, mkFlit(2'b00, 1, 501), 1'b0, 1'b0);
      applyReset();
      applyStimulus(1'b1, mkFlit(2'b01, 0, 502), 1'b1, 1'b1);
      applyStimulus(1'b1, mkFlit(2'b00, 1, 503), 1'b1, 1'b1);
      applyStimulus(1'b1, mkFlit(2'b10, 1, 504), 1'b1, 1'b1);
      drainAll();

      $display("[TB] random traffic");
      for (int i = 0; i < 3000; i++) begin
         rnd = DW'($urandom);
         applyStimulus($urandom_range(0, 3) != 0, rnd, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      end
      drainAll();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
